// File: rtl/evm_vote_controller.sv
// EVM tally sequencer: arms one ballot per ballot_en, records one vote per ballot
// into saturating counters, and in result mode scans the counts and reports winner/tie.
module evm_vote_controller #(
  parameter int CNT_W     = 4,
  parameter int SCAN_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ballot_en,
  input  logic [3:0]       cand_btn,
  input  logic             result_mode,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_d,
  output logic [1:0]       mux_sel,
  output logic             vote_ready,
  output logic             vote_ack,
  output logic             vote_err,
  output logic [1:0]       winner,
  output logic             winner_valid,
  output logic             tie,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int              DW        = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
  localparam logic [DW-1:0]   HOLD_LAST = DW'(SCAN_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt [4];
  logic [DW-1:0]    dwell;
  logic             one_hot, multi_hot;
  logic [1:0]       vote_idx;
  logic [1:0]       best_idx;
  logic [2:0]       n_max;
  logic             best_tie;
  logic             do_clear;

  always_comb begin
    one_hot   = (cand_btn != 4'd0) && ((cand_btn & (cand_btn - 4'd1)) == 4'd0);
    multi_hot = (cand_btn != 4'd0) && !one_hot;
    vote_idx  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (cand_btn[i]) vote_idx = 2'(i);
    end
  end

  // Strict '>' keeps the lowest index among equal maxima.
  always_comb begin
    best_idx = 2'd0;
    n_max    = 3'd0;
    for (int i = 1; i < 4; i++) begin
      if (cnt[i] > cnt[best_idx]) best_idx = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      if (cnt[i] == cnt[best_idx]) n_max = n_max + 3'd1;
    end
    best_tie = (n_max >= 3'd2);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (result_mode)    state_next = RESULT;
        else if (ballot_en) state_next = ARMED;
      end
      ARMED:   if (one_hot) state_next = IDLE;
      RESULT:  if (!result_mode) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign do_clear = (state == IDLE) && clear && !result_mode && !ballot_en;

  // Handshake: vote_ready is high for every cycle a ballot is armed; a valid press
  // while ready is consumed at that edge, raising vote_ack for one cycle and dropping
  // vote_ready in the same cycle. A multi-press pulses vote_err and leaves ready high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vote_ready <= 1'b0;
      vote_ack   <= 1'b0;
      vote_err   <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      state      <= state_next;
      vote_ready <= (state_next == ARMED);
      vote_ack   <= (state == ARMED) && one_hot;
      vote_err   <= (state == ARMED) && multi_hot;
      if ((state == ARMED) && one_hot) begin
        if (cnt[vote_idx] != CNT_MAX) cnt[vote_idx] <= cnt[vote_idx] + 1'b1;
      end else if (do_clear) begin
        for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end
    end
  end

  // Counts are frozen in RESULT, so capturing winner/tie on entry stays accurate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell        <= '0;
      mux_sel      <= 2'd0;
      winner       <= 2'd0;
      tie          <= 1'b0;
      winner_valid <= 1'b0;
    end else if (state_next != RESULT) begin
      dwell        <= '0;
      mux_sel      <= 2'd0;
      winner       <= 2'd0;
      tie          <= 1'b0;
      winner_valid <= 1'b0;
    end else begin
      winner_valid <= 1'b1;
      if (state != RESULT) begin
        winner <= best_idx;
        tie    <= best_tie;
      end else if (dwell == HOLD_LAST) begin
        dwell   <= '0;
        mux_sel <= mux_sel + 2'd1;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  assign cnt_a     = cnt[0];
  assign cnt_b     = cnt[1];
  assign cnt_c     = cnt[2];
  assign cnt_d     = cnt[3];
  assign fsm_state = state;

endmodule

// File: tb/tb_evm_vote_controller.sv
// Directed bench for evm_vote_controller: ballots, multi-press, saturation,
// clear gating, result scan/winner/tie and asynchronous reset mid-ballot.
module tb_evm_vote_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ballot_en;
  logic [3:0] cand_btn;
  logic       result_mode;
  logic       clear;
  logic [3:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic [1:0] mux_sel;
  logic       vote_ready, vote_ack, vote_err;
  logic [1:0] winner;
  logic       winner_valid, tie;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  localparam int S_IDLE = 0, S_ARMED = 1, S_RESULT = 2;

  evm_vote_controller #(.CNT_W(4), .SCAN_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .ballot_en(ballot_en), .cand_btn(cand_btn),
    .result_mode(result_mode), .clear(clear),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d),
    .mux_sel(mux_sel), .vote_ready(vote_ready), .vote_ack(vote_ack),
    .vote_err(vote_err), .winner(winner), .winner_valid(winner_valid),
    .tie(tie), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cast_vote(input logic [3:0] btn);
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    cand_btn  = btn;
    tick();
    cand_btn  = 4'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnts"}, 32'({cnt_a, cnt_b, cnt_c, cnt_d}), 0);
    check({tag, "_mux"}, 32'(mux_sel), 0);
    check({tag, "_hs"}, 32'({vote_ready, vote_ack, vote_err}), 0);
    check({tag, "_win"}, 32'({winner, winner_valid, tie}), 0);
    check({tag, "_state"}, 32'(fsm_state), S_IDLE);
  endtask

  task automatic check_counts(input string tag, input int a, input int b, input int c, input int d);
    check({tag, "_a"}, 32'(cnt_a), a);
    check({tag, "_b"}, 32'(cnt_b), b);
    check({tag, "_c"}, 32'(cnt_c), c);
    check({tag, "_d"}, 32'(cnt_d), d);
  endtask

  initial begin
    rst_n = 1'b0; ballot_en = 1'b0; cand_btn = 4'd0; result_mode = 1'b0; clear = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single vote on candidate 2
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    check("armed_ready", 32'(vote_ready), 1);
    check("armed_state", 32'(fsm_state), S_ARMED);
    cand_btn = 4'b0100;
    tick();
    cand_btn = 4'd0;
    check("v1_ack", 32'(vote_ack), 1);
    check("v1_ready_drop", 32'(vote_ready), 0);
    check("v1_state", 32'(fsm_state), S_IDLE);
    check_counts("v1", 0, 0, 1, 0);
    tick();
    check("v1_ack_pulse", 32'(vote_ack), 0);

    // multi-press rejected, then valid press
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    cand_btn = 4'b0011;
    tick();
    check("multi_err", 32'(vote_err), 1);
    check("multi_ack", 32'(vote_ack), 0);
    check("multi_ready", 32'(vote_ready), 1);
    check_counts("multi", 0, 0, 1, 0);
    cand_btn = 4'd0;
    tick();
    check("multi_err_pulse", 32'(vote_err), 0);
    check("wait_state", 32'(fsm_state), S_ARMED);
    cand_btn = 4'b0001;
    tick();
    cand_btn = 4'd0;
    check("v2_ack", 32'(vote_ack), 1);
    check_counts("v2", 1, 0, 1, 0);

    // saturation on candidate 1
    for (int i = 0; i < 17; i++) begin
      cast_vote(4'b0010);
      check("sat_ack", 32'(vote_ack), 1);
      check("sat_cnt_b", 32'(cnt_b), (i + 1 > 15) ? 15 : i + 1);
    end

    // clear in IDLE
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_counts("clear_idle", 0, 0, 0, 0);

    // build a=3, b=5, c=5
    for (int i = 0; i < 3; i++) cast_vote(4'b0001);
    for (int i = 0; i < 5; i++) cast_vote(4'b0010);
    for (int i = 0; i < 5; i++) cast_vote(4'b0100);

    // clear and result_mode ignored while ARMED
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0; clear = 1'b1; result_mode = 1'b1;
    tick();
    tick();
    check("armed_ignore_state", 32'(fsm_state), S_ARMED);
    check_counts("armed_clear", 3, 5, 5, 0);
    clear = 1'b0; result_mode = 1'b0; cand_btn = 4'b1000;
    tick();
    cand_btn = 4'd0;
    check_counts("pre_result", 3, 5, 5, 1);

    // result_mode wins over ballot_en; tie between 1 and 2
    result_mode = 1'b1; ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    check("res_state", 32'(fsm_state), S_RESULT);
    check("res_valid", 32'(winner_valid), 1);
    check("res_winner", 32'(winner), 1);
    check("res_tie", 32'(tie), 1);
    check("res_ready", 32'(vote_ready), 0);
    check("res_mux0", 32'(mux_sel), 0);
    clear = 1'b1; cand_btn = 4'b0100;
    for (int s = 1; s <= 5; s++) begin
      repeat (7) tick();
      check("scan_hold", 32'(mux_sel), (s - 1) % 4);
      tick();
      check("scan_step", 32'(mux_sel), s % 4);
    end
    clear = 1'b0; cand_btn = 4'd0;
    check_counts("frozen", 3, 5, 5, 1);
    result_mode = 1'b0;
    tick();
    check("exit_state", 32'(fsm_state), S_IDLE);
    check("exit_mux", 32'(mux_sel), 0);
    check("exit_win", 32'({winner, winner_valid, tie}), 0);
    check_counts("after_res", 3, 5, 5, 1);

    // unique winner after one more vote for candidate 2
    cast_vote(4'b0100);
    result_mode = 1'b1;
    tick();
    check("uniq_winner", 32'(winner), 2);
    check("uniq_tie", 32'(tie), 0);
    result_mode = 1'b0;
    tick();

    // asynchronous reset mid-ballot with a button pressed
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    cand_btn = 4'b0001;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    check_all_zero("rst_held");
    cand_btn = 4'd0;
    rst_n = 1'b1;

    // all-zero counts: winner 0 with tie
    result_mode = 1'b1;
    tick();
    check("zero_winner", 32'(winner), 0);
    check("zero_tie", 32'(tie), 1);
    check("zero_valid", 32'(winner_valid), 1);
    result_mode = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/evm_vote_controller.md
Name: evm_vote_controller

Overview:
- Sequencing controller for the EVM tally path. It arbitrates four candidate buttons into four vote counters, one vote per ballot enable.
- It exports the counters to the 4:1 candidate-count mux inputs A–D.
- In result mode it drives the mux select to scan the candidates for display, and reports the winner and any tie.

Parameters:
- CNT_W, 4, width of each candidate vote counter. Matches the 4-bit mux data inputs.
- SCAN_HOLD, 8, number of clock cycles mux_sel dwells on each candidate in RESULT. Must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ballot_en  in  1  presiding-officer enable; arms one ballot.
- cand_btn  in  4  candidate buttons, bit i = candidate i. Debounced, synchronous level.
- result_mode  in  1  level; high requests the result scan.
- clear  in  1  synchronous clear of all counters; honoured only in IDLE.
- cnt_a, cnt_b, cnt_c, cnt_d  out  CNT_W each  vote counts for candidates 0–3; drive mux inputs A–D.
- mux_sel  out  2  mux select S.
- vote_ready  out  1  high while a ballot is armed.
- vote_ack  out  1  one-cycle pulse when a vote is recorded.
- vote_err  out  1  one-cycle pulse when an invalid multi-press is seen.
- winner  out  2  index of the highest count.
- winner_valid  out  1  winner and tie are meaningful.
- tie  out  1  two or more candidates share the maximum.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - All counters, mux_sel, winner, winner_valid, tie, vote_ready, vote_ack and vote_err = 0.
  - Reset mid-ballot discards the pending ballot; no count changes.
- FSM states: IDLE, ARMED, RESULT. All outputs are registered.
- IDLE:
  - result_mode=1 → RESULT. It has priority over ballot_en in the same cycle.
  - Otherwise ballot_en=1 → ARMED; vote_ready=1 from the next cycle.
  - clear=1, only when neither transition is taken → all counters = 0 next cycle.
- ARMED:
  - vote_ready=1. ballot_en, clear and result_mode are ignored.
  - cand_btn exactly one-hot (bit i) → count i increments by 1 and vote_ack pulses for 1 cycle. Next state IDLE; vote_ready drops in the same cycle vote_ack rises.
  - cand_btn with ≥2 bits set → vote_err pulses for 1 cycle, no count changes, stay ARMED.
  - cand_btn=0 → wait indefinitely.
  - Latency: press sampled at edge N → count and vote_ack visible after edge N.
- Saturation: a count at 2^CNT_W−1 holds its value. vote_ack still pulses and the ballot is consumed.
- Held button: after ack the state is IDLE, so a held press cannot cast a second vote. The next ballot needs a new ballot_en, and the same held button will count once in that ballot.
- RESULT:
  - Counters are frozen.
  - mux_sel starts at 0 and advances 0→1→2→3→0 every SCAN_HOLD cycles (wrap-around), continuing while result_mode=1.
  - On the entry cycle, winner/tie are computed from the counts and registered; winner_valid=1 from the cycle after entry.
  - Winner = lowest index among those holding the maximum count.
  - tie=1 iff ≥2 counts equal the maximum. All-zero counts give winner=0, tie=1.
  - result_mode falling → IDLE next cycle: mux_sel=0, winner_valid=0, tie=0, winner=0, dwell counter=0.
- vote_ack and vote_err are never high simultaneously. Both are 0 outside ARMED-exit cycles.

Test Plan:
- Reset → all outputs 0. Then ballot_en pulse, cand_btn=4'b0100 → vote_ack one cycle, cnt_c=1, vote_ready 1→0 with ack, state IDLE.
- ARMED with cand_btn=4'b0011 → vote_err one pulse, counts unchanged, vote_ready stays 1. Then 4'b0001 → cnt_a=1, vote_ack.
- 17 ballots on candidate 1 with CNT_W=4 → cnt_b saturates at 15; 17th still acks.
- Counts a=3, b=5, c=5, d=1, result_mode=1 → winner=1, tie=1, winner_valid from the cycle after entry. mux_sel steps 0,1,2,3,0 each 8 cycles. result_mode=0 → mux_sel=0, winner_valid=0.
- clear=1 in IDLE → all counts 0. clear=1 while ARMED or in RESULT → ignored. result_mode and ballot_en high together in IDLE → RESULT taken.
- rst_n low during ARMED with a button pressed → no count change, all outputs 0 asynchronously.
